// File: rtl/ir_nec_pkg.sv
// NEC infrared protocol constants shared by ir_decoder and ir_encoder:
// nominal durations, inclusive acceptance windows (microseconds) and FSM states.
package ir_nec_pkg;

  localparam int FRAME_BITS = 32;
  localparam int DUR_W      = 14;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  localparam int LEAD_MARK_US  = 9000;
  localparam int LEAD_SPACE_US = 4500;
  localparam int REP_SPACE_US  = 2250;
  localparam int BIT_MARK_US   = 560;
  localparam int ZERO_SPACE_US = 560;
  localparam int ONE_SPACE_US  = 1690;

  localparam int LEAD_MARK_MIN  = 8000;
  localparam int LEAD_MARK_MAX  = 10000;
  localparam int LEAD_SPACE_MIN = 4000;
  localparam int LEAD_SPACE_MAX = 5000;
  localparam int REP_SPACE_MIN  = 2000;
  localparam int REP_SPACE_MAX  = 2500;
  localparam int BIT_MARK_MIN   = 400;
  localparam int BIT_MARK_MAX   = 720;
  localparam int ZERO_SPACE_MIN = 400;
  localparam int ZERO_SPACE_MAX = 720;
  localparam int ONE_SPACE_MIN  = 1400;
  localparam int ONE_SPACE_MAX  = 1900;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP_MARK,
    ST_REP_MARK
  } ir_state_e;

  function automatic logic in_window(input logic [DUR_W-1:0] dur, input int lo, input int hi);
    return (int'(dur) >= lo) && (int'(dur) <= hi);
  endfunction

  function automatic logic exceeds(input logic [DUR_W-1:0] dur, input int hi);
    return int'(dur) > hi;
  endfunction

endpackage

// File: rtl/ir_decoder_if.sv
// Consumer-side bundle of ir_decoder: decoded word with valid/ready plus side pulses.
interface ir_decoder_if;
  logic [31:0] cmd;
  logic        valid;
  logic        ready;
  logic        rpt;
  logic        err;
  logic        overrun;

  modport master (output cmd, valid, rpt, err, overrun, input ready);
  modport slave  (input cmd, valid, rpt, err, overrun, output ready);
endinterface

// File: rtl/ir_pulse_timer.sv
// Synchronizes the raw receiver line, flags mark start/end edges one cycle late
// and measures the time since the previous edge in microseconds.
module ir_pulse_timer
  import ir_nec_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ir_in,
  output logic             mark_start,
  output logic             mark_end,
  output logic             level,
  output logic [DUR_W-1:0] dur_us
);

  localparam int   DIV      = (CLK_HZ >= 2_000_000) ? CLK_HZ / 1_000_000 : 1;
  localparam int   PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic IDLE_RAW = ACTIVE_LOW;

  logic [1:0]       sync_q;
  logic             lvl_q;
  logic             start_q;
  logic             end_q;
  logic [PW-1:0]    pre_q;
  logic [DUR_W-1:0] dur_q;
  logic             mark_now;
  logic             tick;

  assign mark_now = sync_q[1] ^ ACTIVE_LOW;
  assign tick     = (pre_q == PW'(DIV - 1));

  // NOTE: every register here is sequential state, so all updates use <= and
  // each one sees the pre-edge value of the others (the edge detector relies on it).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {2{IDLE_RAW}};
      lvl_q   <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      pre_q   <= '0;
      dur_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], ir_in};
      lvl_q   <= mark_now;
      start_q <= mark_now & ~lvl_q;
      end_q   <= ~mark_now & lvl_q;
      pre_q   <= tick ? '0 : pre_q + 1'b1;
      // Restart on the registered edge so dur_q still holds the full length while the pulse is up.
      if (start_q | end_q)
        dur_q <= tick ? DUR_W'(1) : '0;
      else if (tick && dur_q != DUR_MAX)
        dur_q <= dur_q + 1'b1;
    end
  end

  assign mark_start = start_q;
  assign mark_end   = end_q;
  assign level      = lvl_q;
  assign dur_us     = dur_q;

endmodule

// File: rtl/ir_decoder.sv
// NEC infrared frame decoder: times marks/spaces, assembles the 32-bit word
// LSB-first and hands it over with valid/ready plus repeat/error/overrun pulses.
module ir_decoder
  import ir_nec_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit CHECK_INV  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ir_in,
  ir_decoder_if.master bus
);

  localparam int CNT_W = $clog2(FRAME_BITS);

  logic             mark_start;
  logic             mark_end;
  logic             level;
  logic [DUR_W-1:0] dur_us;

  ir_pulse_timer #(
    .CLK_HZ     (CLK_HZ),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .ir_in      (ir_in),
    .mark_start (mark_start),
    .mark_end   (mark_end),
    .level      (level),
    .dur_us     (dur_us)
  );

  ir_state_e        state_q;
  logic [31:0]      sr_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             last_ok_q;
  logic [31:0]      cmd_q;
  logic             valid_q;
  logic             rpt_q;
  logic             err_q;
  logic             ovr_q;
  logic             inv_ok;
  logic             bad_dur;

  assign inv_ok = !CHECK_INV || (sr_q[31:24] == ~sr_q[23:16]);

  // A measured phase outside its window, or a phase still running past its maximum.
  // NOTE: bad_dur gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    bad_dur = 1'b0;
    case (state_q)
      ST_LEAD_MARK:  bad_dur = mark_end ? !in_window(dur_us, LEAD_MARK_MIN, LEAD_MARK_MAX)
                                        : (level && exceeds(dur_us, LEAD_MARK_MAX));
      ST_LEAD_SPACE: bad_dur = mark_start ? !(in_window(dur_us, LEAD_SPACE_MIN, LEAD_SPACE_MAX) ||
                                              in_window(dur_us, REP_SPACE_MIN, REP_SPACE_MAX))
                                          : (!level && exceeds(dur_us, LEAD_SPACE_MAX));
      ST_BIT_SPACE:  bad_dur = mark_start ? !(in_window(dur_us, ZERO_SPACE_MIN, ZERO_SPACE_MAX) ||
                                              in_window(dur_us, ONE_SPACE_MIN, ONE_SPACE_MAX))
                                          : (!level && exceeds(dur_us, ONE_SPACE_MAX));
      ST_STOP_MARK:  bad_dur = mark_end ? (!in_window(dur_us, BIT_MARK_MIN, BIT_MARK_MAX) || !inv_ok)
                                        : (level && exceeds(dur_us, BIT_MARK_MAX));
      ST_BIT_MARK,
      ST_REP_MARK:   bad_dur = mark_end ? !in_window(dur_us, BIT_MARK_MIN, BIT_MARK_MAX)
                                        : (level && exceeds(dur_us, BIT_MARK_MAX));
      default:       bad_dur = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      last_ok_q <= 1'b0;
      cmd_q     <= '0;
      valid_q   <= 1'b0;
      rpt_q     <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rpt_q <= 1'b0;
      err_q <= 1'b0;
      ovr_q <= 1'b0;
      if (valid_q && bus.ready)
        valid_q <= 1'b0;

      if (bad_dur) begin
        err_q     <= 1'b1;
        last_ok_q <= 1'b0;
        state_q   <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE:       if (mark_start) state_q <= ST_LEAD_MARK;
          ST_LEAD_MARK:  if (mark_end)   state_q <= ST_LEAD_SPACE;
          ST_LEAD_SPACE: if (mark_start) begin
            if (in_window(dur_us, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
              bit_cnt_q <= '0;
              state_q   <= ST_BIT_MARK;
            end else begin
              state_q   <= ST_REP_MARK;
            end
          end
          ST_BIT_MARK:   if (mark_end)   state_q <= ST_BIT_SPACE;
          ST_BIT_SPACE:  if (mark_start) begin
            sr_q      <= {in_window(dur_us, ONE_SPACE_MIN, ONE_SPACE_MAX), sr_q[31:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            state_q   <= (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) ? ST_STOP_MARK : ST_BIT_MARK;
          end
          ST_STOP_MARK:  if (mark_end) begin
            state_q   <= ST_IDLE;
            last_ok_q <= 1'b1;
            // A held word is only replaced when the consumer takes it this very cycle.
            if (!valid_q || bus.ready) begin
              cmd_q   <= sr_q;
              valid_q <= 1'b1;
            end else begin
              ovr_q   <= 1'b1;
            end
          end
          ST_REP_MARK:   if (mark_end) begin
            rpt_q   <= last_ok_q;
            state_q <= ST_IDLE;
          end
          default:       state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.cmd     = cmd_q;
  assign bus.valid   = valid_q;
  assign bus.rpt     = rpt_q;
  assign bus.err     = err_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_ir_decoder.sv
// Directed + randomized bench for ir_decoder; one tick per clock (CLK_HZ = 1 MHz)
// so every drive length below is directly in microseconds.
module tb_ir_decoder;

  localparam int CLK_HZ = 1_000_000;

  logic clk = 1'b0;
  logic rst;
  logic ir_in;

  always #5 clk = ~clk;

  ir_decoder_if dec_if ();
  ir_decoder_if ni_if ();

  ir_decoder #(.CLK_HZ(CLK_HZ), .ACTIVE_LOW(1'b1), .CHECK_INV(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .ir_in (ir_in),
    .bus   (dec_if)
  );

  ir_decoder #(.CLK_HZ(CLK_HZ), .ACTIVE_LOW(1'b1), .CHECK_INV(1'b0)) dut_ni (
    .clk   (clk),
    .rst   (rst),
    .ir_in (ir_in),
    .bus   (ni_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_err    = 0;
  int n_rpt    = 0;
  int n_ovr    = 0;

  always @(negedge clk) begin
    if (dec_if.err)     n_err++;
    if (dec_if.rpt)     n_rpt++;
    if (dec_if.overrun) n_ovr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: bits in arrival order; arrival index i becomes word bit i.
  bit sent_bits[$];

  function automatic logic [31:0] model_word();
    logic [31:0] w = '0;
    foreach (sent_bits[i]) w[i] = sent_bits[i];
    return w;
  endfunction

  function automatic logic inv_ok(input logic [31:0] w);
    return w[31:24] == ~w[23:16];
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic lvl, input int us);
    ir_in = lvl;
    wait_cycles(us);
  endtask

  task automatic mark(input int us);
    seg(1'b0, us);
  endtask

  task automatic space(input int us);
    seg(1'b1, us);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input int one_us, input bit jitter);
    for (int i = 0; i < n; i++) begin
      mark(jitter ? rnd(420, 700) : 560);
      space(w[i] ? one_us : (jitter ? rnd(420, 700) : 560));
      sent_bits.push_back(w[i]);
    end
  endtask

  // Leaves the line released (end of stop mark) at the current cycle, "cycle 0".
  task automatic send_frame(input logic [31:0] w, input int one_us, input bit jitter);
    sent_bits.delete();
    mark(jitter ? rnd(8500, 9500) : 9000);
    space(jitter ? rnd(4100, 4900) : 4500);
    send_bits(w, 32, one_us, jitter);
    mark(jitter ? rnd(420, 700) : 560);
    ir_in = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] w1;
    logic [7:0]  c;
    int e0, r0, o0;

    rst = 1'b1;
    ir_in = 1'b1;
    dec_if.ready = 1'b1;
    ni_if.ready  = 1'b1;
    @(posedge clk);
    #1;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(2);

    check("rst_valid",   32'(dec_if.valid),   32'd0);
    check("rst_cmd",     dec_if.cmd,          32'd0);
    check("rst_rpt",     32'(dec_if.rpt),     32'd0);
    check("rst_err",     32'(dec_if.err),     32'd0);
    check("rst_overrun", 32'(dec_if.overrun), 32'd0);

    // Repeat code with no earlier frame: silently ignored.
    e0 = n_err; r0 = n_rpt;
    mark(9000); space(2250); mark(560); ir_in = 1'b1;
    wait_cycles(10);
    check("rep_cold_rpt", 32'(n_rpt - r0), 32'd0);
    check("rep_cold_err", 32'(n_err - e0), 32'd0);

    // Nominal frame, ready high: valid exactly 4 cycles after the stop mark ends.
    e0 = n_err;
    space(100);
    send_frame(32'hED120707, 1690, 1'b0);
    w = model_word();
    wait_cycles(3);
    check("nom_valid_c3", 32'(dec_if.valid), 32'd0);
    wait_cycles(1);
    check("nom_valid_c4", 32'(dec_if.valid), 32'd1);
    check("nom_cmd",      dec_if.cmd,        w);
    check("nom_cmd_const", dec_if.cmd,       32'hED120707);
    wait_cycles(1);
    check("nom_valid_drop", 32'(dec_if.valid), 32'd0);
    check("nom_err",        32'(n_err - e0),   32'd0);

    // Repeat code after a good frame.
    e0 = n_err; r0 = n_rpt;
    space(100);
    mark(9000); space(2250); mark(560); ir_in = 1'b1;
    wait_cycles(4);
    check("rep_rpt_c4", 32'(dec_if.rpt), 32'd1);
    wait_cycles(10);
    check("rep_rpt_cnt", 32'(n_rpt - r0),    32'd1);
    check("rep_valid",   32'(dec_if.valid),  32'd0);
    check("rep_cmd",     dec_if.cmd,         w);
    check("rep_err",     32'(n_err - e0),    32'd0);

    // Broken inverse byte: error here, accepted by the instance without the check.
    e0 = n_err;
    space(100);
    send_frame(32'hEC120707, 1690, 1'b0);
    w = model_word();
    wait_cycles(4);
    check("inv_err_c4",   32'(dec_if.err),  32'(!inv_ok(w)));
    check("inv_ni_valid", 32'(ni_if.valid), 32'd1);
    check("inv_ni_cmd",   ni_if.cmd,        w);
    wait_cycles(10);
    check("inv_err_cnt", 32'(n_err - e0),   32'd1);
    check("inv_valid",   32'(dec_if.valid), 32'd0);

    // Consumer stalled: second frame (ones sent as 1400 us spaces) overruns.
    dec_if.ready = 1'b0;
    e0 = n_err; o0 = n_ovr;
    space(100);
    send_frame(32'hED120707, 1690, 1'b0);
    w1 = model_word();
    wait_cycles(4);
    check("ovr_first_valid", 32'(dec_if.valid), 32'd1);
    check("ovr_first_cmd",   dec_if.cmd,        w1);
    space(100);
    send_frame(32'hF40B0707, 1400, 1'b0);
    w = model_word();
    wait_cycles(4);
    check("ovr_pulse_c4", 32'(dec_if.overrun), 32'd1);
    check("edge1400_ni_cmd", ni_if.cmd,        w);
    wait_cycles(5);
    check("ovr_cnt",   32'(n_ovr - o0),   32'd1);
    check("ovr_held",  dec_if.cmd,        w1);
    check("ovr_valid", 32'(dec_if.valid), 32'd1);
    check("ovr_err",   32'(n_err - e0),   32'd0);
    dec_if.ready = 1'b1;
    wait_cycles(1);
    dec_if.ready = 1'b0;
    check("ovr_valid_drop", 32'(dec_if.valid), 32'd0);
    dec_if.ready = 1'b1;

    // Bit space of 1000 us falls between the two windows.
    e0 = n_err;
    space(100);
    mark(9000); space(4500);
    send_bits(32'h0000_0005, 3, 1690, 1'b0);
    mark(560); space(1000);
    ir_in = 1'b0;
    wait_cycles(3);
    check("gap_err_c3", 32'(dec_if.err), 32'd0);
    wait_cycles(1);
    check("gap_err_c4", 32'(dec_if.err), 32'd1);
    wait_cycles(556);
    ir_in = 1'b1;
    wait_cycles(50);
    check("gap_err_cnt", 32'(n_err - e0), 32'd1);

    // Leader mark held 11 ms: timeout at 10001 us, nothing after release.
    e0 = n_err; r0 = n_rpt;
    ir_in = 1'b0;
    wait_cycles(10004);
    check("lto_err_early", 32'(dec_if.err), 32'd0);
    wait_cycles(1);
    check("lto_err_fire",  32'(dec_if.err), 32'd1);
    wait_cycles(11000 - 10005);
    ir_in = 1'b1;
    wait_cycles(3000);
    check("lto_err_cnt", 32'(n_err - e0),   32'd1);
    check("lto_rpt",     32'(n_rpt - r0),   32'd0);
    check("lto_valid",   32'(dec_if.valid), 32'd0);

    // Reset in the middle of a frame aborts it silently.
    e0 = n_err;
    space(100);
    mark(9000); space(4500);
    send_bits($urandom(), 10, 1690, 1'b0);
    mark(560); space(100);
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(200);
    check("rst_mid_valid", 32'(dec_if.valid), 32'd0);
    check("rst_mid_err",   32'(n_err - e0),   32'd0);

    // Randomized word and timing jitter after the abort.
    e0 = n_err;
    c = 8'($urandom());
    w = {~c, c, 16'($urandom())};
    send_frame(w, rnd(1400, 1900), 1'b1);
    wait_cycles(3);
    check("rnd_valid_c3", 32'(dec_if.valid), 32'd0);
    wait_cycles(1);
    check("rnd_valid_c4", 32'(dec_if.valid), 32'd1);
    check("rnd_cmd",      dec_if.cmd,        model_word());
    check("rnd_err",      32'(n_err - e0),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
